// File: rtl/i2c_slave_pkg.sv
// Shared FSM state type and bus constants for the I2C slave register bank.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrite,
    StWriteAck,
    StRead,
    StReadAck
  } state_e;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam logic       ACK           = 1'b0;
  localparam logic       NACK          = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser producing registered SCL edge and START/STOP pulses.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Bus idles high, so reset the chain to 1 to avoid a spurious START.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl      <= 1'b1;
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl      <= scl_s;
      sda      <= sda_s;
      scl_rise <= scl_s & ~scl;
      scl_fall <= ~scl_s & scl;
      start    <= scl & scl_s & sda & ~sda_s;
      stop     <= scl & scl_s & ~sda & sda_s;
    end
  end

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C slave with pointer/auto-increment access to a dual-ported register bank.
// Define I2C_SLAVE_GENCALL_EN to accept general-call (7'h00) writes.
module i2c_slave_regbank
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic [7:0]       loc_din,
  input  logic             loc_we,
  output logic [7:0]       loc_dout,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

`ifdef I2C_SLAVE_GENCALL_EN
  localparam bit GenCallEn = 1'b1;
`else
  localparam bit GenCallEn = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda     (sda_s),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  state_e           state;
  logic [3:0]       cnt;
  logic [7:0]       shreg, tx, rx_byte;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       bank [DEPTH];
  logic             i2c_we, gen_call, addr_hit;

  assign rx_byte  = {shreg[6:0], sda_s};
  assign gen_call = GenCallEn && (shreg[7:1] == GEN_CALL_ADDR) && (shreg[0] == 1'b0);
  assign addr_hit = (shreg[7:1] == SLAVE_ADDR) || gen_call;
  assign i2c_we   = (state == StWrite) && scl_rise && (cnt == 4'd7);

  // I2C write is placed last so it wins a same-address collision with the local port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
      loc_dout <= '0;
    end else begin
      if (loc_we) bank[loc_addr] <= loc_din;
      if (i2c_we) bank[ptr] <= rx_byte;
      loc_dout <= bank[loc_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= i2c_we;
      if (i2c_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
      if (stop) begin
        state  <= StIdle;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        state  <= StAddr;
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else begin
        unique case (state)
          StIdle: ;
          StAddr, StPtr, StWrite: begin
            if (scl_rise && cnt < 4'd8) begin
              shreg <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7 && state == StPtr) ptr <= rx_byte[PTR_W-1:0];
              if (cnt == 4'd7 && state == StWrite) ptr <= ptr + 1'b1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= '0;
              if (state != StAddr) begin
                sda_oe <= ~ACK;
                state  <= (state == StPtr) ? StPtrAck : StWriteAck;
              end else if (addr_hit) begin
                sda_oe <= ~ACK;
                busy   <= 1'b1;
                state  <= StAddrAck;
              end else begin
                busy  <= 1'b0;
                state <= StIdle;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              cnt <= '0;
              if (shreg[0]) begin
                tx     <= bank[ptr];
                sda_oe <= ~bank[ptr][7];
                state  <= StRead;
              end else begin
                sda_oe <= 1'b0;
                state  <= StPtr;
              end
            end
          end
          StPtrAck, StWriteAck: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= StWrite;
            end
          end
          StRead: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= StReadAck;
            end else if (scl_fall && cnt != 4'd0) begin
              sda_oe <= ~tx[6];
              tx     <= {tx[6:0], 1'b0};
            end
          end
          StReadAck: begin
            // cnt marks that the master ACKed and the next byte is due at the fall.
            if (scl_rise) begin
              if (sda_s == ACK) begin
                ptr <= ptr + 1'b1;
                cnt <= 4'd1;
              end else begin
                state <= StIdle;
              end
            end else if (scl_fall && cnt == 4'd1) begin
              cnt    <= '0;
              tx     <= bank[ptr];
              sda_oe <= ~bank[ptr][7];
              state  <= StRead;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Self-checking bench: bit-banged I2C master, write/read scoreboards, local-port checks.
module tb_i2c_slave_regbank;

  localparam int unsigned DEPTH = 32;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset, scl_m, sda_m, sda_bus;
  logic       sda_oe, wr_strobe, busy, loc_we;
  logic [4:0] loc_addr, wr_addr;
  logic [7:0] loc_din, loc_dout, wr_data;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_regbank #(
    .SLAVE_ADDR (7'h42),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .loc_addr (loc_addr),
    .loc_din  (loc_din),
    .loc_we   (loc_we),
    .loc_dout (loc_dout),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] mem [DEPTH];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_strobes = 0;
  int         oe_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write scoreboard: each wr_strobe pops the next expected (addr, data).
  always @(negedge clk) begin
    wr_t e;
    if (sda_oe) oe_cnt++;
    if (wr_strobe) begin
      n_strobes++;
      if (wq.size() == 0) begin
        check_eq("wr_unexpected", 32'(wr_strobe), 32'd0);
      end else begin
        e = wq.pop_front();
        check_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
        check_eq("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  // collide: drop loc_we right after the cycle the DUT commits the I2C byte.
  task automatic send_byte(input logic [7:0] b, input bit collide, output bit acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; qwait();
      scl_m = 1'b1;
      if (collide && i == 0) begin
        for (int k = 0; k < 2 * Q; k++) begin
          @(posedge clk); #1;
          if (wr_strobe) loc_we = 1'b0;
        end
        loc_we = 1'b0;
      end else begin
        qwait(); qwait();
      end
      scl_m = 1'b0; qwait();
    end
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    acked = (sda_bus == 1'b0);
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      qwait(); scl_m = 1'b1;
      qwait(); d[i] = sda_bus;
      qwait(); scl_m = 1'b0;
    end
    qwait(); sda_m = ack ? 1'b0 : 1'b1;
    qwait(); scl_m = 1'b1;
    qwait(); qwait(); scl_m = 1'b0;
    qwait(); sda_m = 1'b1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
    mem[a] = d;
  endtask

  task automatic loc_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_din = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic loc_rd(input string tag, input logic [4:0] a);
    @(negedge clk);
    loc_addr = a;
    @(posedge clk); #1;
    check_eq(tag, 32'(loc_dout), 32'(mem[a]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ack;
    logic [7:0] d;
    int         s0, o0;

    scl_m = 1'b1; sda_m = 1'b1; loc_we = 1'b0; loc_addr = '0; loc_din = '0; reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    repeat (4) @(posedge clk); #1;
    check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_loc_dout", 32'(loc_dout), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);

    // Pointer write then two data bytes with auto-increment.
    s0 = n_strobes;
    i2c_start();
    send_byte(8'h84, 1'b0, ack); check_eq("t1_addr_ack", 32'(ack), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h05, 1'b0, ack); check_eq("t1_ptr_ack", 32'(ack), 32'd1);
    push_wr(5'd5, 8'hA5);
    send_byte(8'hA5, 1'b0, ack); check_eq("t1_d0_ack", 32'(ack), 32'd1);
    push_wr(5'd6, 8'h3C);
    send_byte(8'h3C, 1'b0, ack); check_eq("t1_d1_ack", 32'(ack), 32'd1);
    i2c_stop(); qwait();
    check_eq("t1_busy_stop", 32'(busy), 32'd0);
    check_eq("t1_strobes", 32'(n_strobes - s0), 32'd2);
    loc_rd("t1_loc6", 5'd6);
    loc_rd("t1_loc5", 5'd5);

    // Pointer wrap at DEPTH-1.
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    send_byte(8'h1F, 1'b0, ack);
    push_wr(5'd31, 8'h11);
    send_byte(8'h11, 1'b0, ack);
    push_wr(5'd0, 8'h22);
    send_byte(8'h22, 1'b0, ack);
    i2c_stop();
    loc_rd("t2_loc31", 5'd31);
    loc_rd("t2_loc0", 5'd0);

    // Pointer write, repeated START, 3-byte read with final NACK.
    loc_wr(5'd3, 8'h5C);
    loc_wr(5'd4, 8'hE1);
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    send_byte(8'h03, 1'b0, ack);
    i2c_start();
    send_byte(8'h85, 1'b0, ack); check_eq("t3_rd_addr_ack", 32'(ack), 32'd1);
    rq.push_back(mem[3]); rq.push_back(mem[4]); rq.push_back(mem[5]);
    for (int i = 0; i < 3; i++) begin
      recv_byte(i < 2, d);
      check_eq($sformatf("t3_rd%0d", i), 32'(d), 32'(rq.pop_front()));
    end
    qwait();
    check_eq("t3_oe_release", 32'(sda_oe), 32'd0);
    i2c_stop();

    // Wrong address: no ACK, no drive, no writes.
    s0 = n_strobes; o0 = oe_cnt;
    i2c_start();
    send_byte(8'h86, 1'b0, ack); check_eq("t4_addr_nack", 32'(ack), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    send_byte(8'h55, 1'b0, ack); check_eq("t4_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    check_eq("t4_oe_never", 32'(oe_cnt - o0), 32'd0);
    check_eq("t4_no_strobe", 32'(n_strobes - s0), 32'd0);
    loc_rd("t4_loc5", 5'd5);

    // Same-cycle local and I2C write to address 9: I2C wins.
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    send_byte(8'h09, 1'b0, ack);
    @(negedge clk);
    loc_addr = 5'd9; loc_din = 8'h77; loc_we = 1'b1;
    push_wr(5'd9, 8'h88);
    send_byte(8'h88, 1'b1, ack);
    i2c_stop();
    loc_rd("t5_collide", 5'd9);

    // Reset mid-READ while driving SDA low.
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    send_byte(8'h03, 1'b0, ack);
    i2c_start();
    send_byte(8'h85, 1'b0, ack);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sda_oe) break;
    end
    check_eq("t6_oe_driven", 32'(sda_oe), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rst_oe", 32'(sda_oe), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    i2c_stop();
    loc_rd("t6_loc3_cleared", 5'd3);

`ifdef I2C_SLAVE_GENCALL_EN
    i2c_start();
    send_byte(8'h00, 1'b0, ack); check_eq("t7_gc_ack", 32'(ack), 32'd1);
    check_eq("t7_gc_busy", 32'(busy), 32'd1);
    send_byte(8'h02, 1'b0, ack);
    push_wr(5'd2, 8'h5A);
    send_byte(8'h5A, 1'b0, ack);
    i2c_stop();
    loc_rd("t7_gc_loc2", 5'd2);
    i2c_start();
    send_byte(8'h01, 1'b0, ack); check_eq("t7_gc_rd_nack", 32'(ack), 32'd0);
    i2c_stop();
`else
    s0 = n_strobes;
    i2c_start();
    send_byte(8'h00, 1'b0, ack); check_eq("t7_gc_nack", 32'(ack), 32'd0);
    send_byte(8'h02, 1'b0, ack);
    i2c_stop();
    check_eq("t7_gc_no_strobe", 32'(n_strobes - s0), 32'd0);
`endif

    repeat (10) @(posedge clk);
    check_eq("wr_pending", 32'(wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
